lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_PWRUP, default 2000000, power-up wait cycles (40 ms at 50 MHz).
REQ-002 Parameter T_SETUP, default 2, cycles RS/DATA are stable before EN rises.
REQ-003 Parameter T_EN, default 12, cycles EN is held high.
REQ-004 Parameter T_HOLD, default 2, cycles RS/DATA are held after EN falls.
REQ-005 Parameter T_EXEC, default 1850, post-strobe wait cycles for normal commands and data.
REQ-006 Parameter T_CLR, default 76000, post-strobe wait cycles for clear/home commands.
REQ-007 i_clk  input  1  single clock, rising edge; one clock only.
REQ-008 i_reset  input  1  synchronous, active-low reset.
REQ-009 i_lcd_word  input  32  core LCD register word: [31] power, [9] RS, [8] strobe toggle, [7:0] data.
REQ-010 o_lcd_on  output  1  LCD power/backlight, equal to registered i_lcd_word[31].
REQ-011 o_lcd_en  output  1  HD44780 enable strobe.
REQ-012 o_lcd_rs  output  1  register select, 0 = command, 1 = data.
REQ-013 o_lcd_rw  output  1  read/write select, tied 0 (write only).
REQ-014 o_lcd_data  output  8  data bus.
REQ-015 o_lcd_busy  output  1  high while init runs, a transfer runs, or the buffer is full.
REQ-016 o_lcd_ovf  output  1  sticky flag, a request was dropped.

Function
REQ-017 Register i_lcd_word[8] once; a request is any cycle where it differs from the registered copy; capture {RS, data} from the same cycle.
REQ-018 Provide a one-entry request buffer; a request while the buffer is empty fills it.
REQ-019 A request while the buffer is full is dropped, the buffer is unchanged, and o_lcd_ovf sets and stays set until reset.
REQ-020 States: PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT.
REQ-021 PWRUP: count T_PWRUP cycles, then go to INIT.
REQ-022 INIT: issue commands 0x38, 0x0C, 0x01, 0x06 in order (RS=0), each through SETUP/EN_HI/HOLD/WAIT, then go to IDLE.
REQ-023 Requests arriving during PWRUP/INIT are buffered per REQ-018/019 and serviced after INIT.
REQ-024 IDLE: if the buffer is full, load RS/data to outputs, empty the buffer, and go to SETUP the next cycle; otherwise stay.
REQ-025 SETUP lasts T_SETUP cycles, EN_HI T_EN cycles (o_lcd_en=1 only here), HOLD T_HOLD cycles.
REQ-026 WAIT lasts T_CLR cycles if RS=0 and data is 0x01, 0x02 or 0x03; otherwise it lasts T_EXEC cycles.
REQ-027 After WAIT, return to IDLE, or to the next INIT step.
REQ-028 o_lcd_rs/o_lcd_data change only on entry to SETUP and are constant through SETUP..WAIT.
REQ-029 A buffer fill and a buffer drain in the same cycle (IDLE consume plus new request) shall both occur, leaving the buffer full with the new request.
REQ-030 The state counter is 21 bits wide, loads (duration-1) on state entry, and decrements to 0; all durations are at least 1.
REQ-031 o_lcd_busy = (state != IDLE) | buffer full.
REQ-032 o_lcd_on tracks i_lcd_word[31] with 1-cycle latency in every state, independent of the FSM.

Reset
REQ-033 On any i_clk edge with i_reset=0: state=PWRUP, counter loads T_PWRUP-1, buffer is emptied, and o_lcd_ovf=0.
REQ-034 Reset outputs: o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_lcd_on=0, o_lcd_busy=1.
REQ-035 The toggle-history register loads the current i_lcd_word[8] during reset, so no spurious request follows reset release.
REQ-036 Reset asserted mid-transfer aborts it in the same cycle, with o_lcd_en=0 on the next edge.

Verification (T_PWRUP=10, T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=5, T_CLR=20)
REQ-037 Release reset, no input -> busy=1 for 10 cycles, then 4 EN pulses of 3 cycles with data 0x38, 0x0C, 0x01, 0x06; gap after 0x01 is 20 cycles; busy=0 afterwards.
REQ-038 In IDLE, set [9]=1, [7:0]=0x41, toggle [8] -> o_lcd_rs=1, o_lcd_data=0x41, EN high exactly 3 cycles after 2 setup cycles; busy=1 for 1+2+3+2+5 cycles.
REQ-039 Send 0x02 with RS=0 -> WAIT lasts 20 cycles; send 0x80 -> WAIT lasts 5 cycles.
REQ-040 Three toggles during one transfer -> 2nd is buffered and later sent, 3rd is dropped, o_lcd_ovf=1 until reset.
REQ-041 Assert reset during EN_HI -> next edge o_lcd_en=0, state=PWRUP, o_lcd_ovf=0; the stale buffered request is never sent.
REQ-042 Toggle [31] during a transfer -> o_lcd_on follows with 1-cycle latency; transfer timing is unaffected.

Source files
------------

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write-only controller with power-up init sequence,
// one-entry request buffer and sticky overflow flag.
`default_nettype none

module lcd_ctrl #(
  parameter int T_PWRUP = 2000000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 1850,
  parameter int T_CLR   = 76000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_busy,
  output logic        o_lcd_ovf
);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_SETUP = 3'd3;
  localparam logic [2:0] S_EN_HI = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;

  localparam logic [20:0] C_PWRUP = 21'(T_PWRUP - 1);
  localparam logic [20:0] C_SETUP = 21'(T_SETUP - 1);
  localparam logic [20:0] C_EN    = 21'(T_EN - 1);
  localparam logic [20:0] C_HOLD  = 21'(T_HOLD - 1);
  localparam logic [20:0] C_EXEC  = 21'(T_EXEC - 1);
  localparam logic [20:0] C_CLR   = 21'(T_CLR - 1);

  logic [2:0]  state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        init_mode_q, init_mode_d;
  logic        toggle_q;
  logic        on_q;
  logic        buf_full_q, buf_full_d;
  logic        buf_rs_q, buf_rs_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        ovf_q, ovf_d;

  logic        req;
  logic        drain;
  logic        long_cmd;
  logic        unused_word;

  assign unused_word = ^i_lcd_word[30:10];

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign req      = i_lcd_word[8] ^ toggle_q;
  assign drain    = (state_q == S_IDLE) && buf_full_q;
  // Clear display and return home need the long execution time.
  assign long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    init_mode_d = init_mode_q;
    rs_d        = rs_q;
    data_d      = data_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == 21'd0) begin
          state_d     = S_INIT;
          init_idx_d  = 2'd0;
          init_mode_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      S_INIT: begin
        rs_d    = 1'b0;
        data_d  = init_cmd(init_idx_q);
        state_d = S_SETUP;
        cnt_d   = C_SETUP;
      end
      S_IDLE: begin
        if (buf_full_q) begin
          rs_d    = buf_rs_q;
          data_d  = buf_data_q;
          state_d = S_SETUP;
          cnt_d   = C_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 21'd0) begin
          state_d = S_EN_HI;
          cnt_d   = C_EN;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      S_EN_HI: begin
        if (cnt_q == 21'd0) begin
          state_d = S_HOLD;
          cnt_d   = C_HOLD;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 21'd0) begin
          state_d = S_WAIT;
          cnt_d   = long_cmd ? C_CLR : C_EXEC;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 21'd0) begin
          if (init_mode_q && init_idx_q != 2'd3) begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = S_INIT;
          end else begin
            init_mode_d = 1'b0;
            state_d     = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = C_PWRUP;
      end
    endcase
  end

  // A drain and a fill may coincide; the new request then occupies the slot.
  always_comb begin
    buf_full_d = buf_full_q && !drain;
    buf_rs_d   = buf_rs_q;
    buf_data_d = buf_data_q;
    ovf_d      = ovf_q;
    if (req) begin
      if (!buf_full_q || drain) begin
        buf_full_d = 1'b1;
        buf_rs_d   = i_lcd_word[9];
        buf_data_d = i_lcd_word[7:0];
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    toggle_q <= i_lcd_word[8];
    if (!i_reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= C_PWRUP;
      init_idx_q  <= 2'd0;
      init_mode_q <= 1'b0;
      on_q        <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_rs_q    <= 1'b0;
      buf_data_q  <= 8'h00;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      init_mode_q <= init_mode_d;
      on_q        <= i_lcd_word[31];
      buf_full_q  <= buf_full_d;
      buf_rs_q    <= buf_rs_d;
      buf_data_q  <= buf_data_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_lcd_on   = on_q;
  assign o_lcd_en   = (state_q == S_EN_HI);
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;
  assign o_lcd_busy = (state_q != S_IDLE) || buf_full_q;
  assign o_lcd_ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed, table-driven bench for lcd_ctrl with short timing parameters.
`default_nettype none

module tb_lcd_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] word;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_busy, lcd_ovf;
  logic [7:0]  lcd_data;

  int checks = 0;
  int errors = 0;

  lcd_ctrl #(
    .T_PWRUP(10), .T_SETUP(2), .T_EN(3), .T_HOLD(2), .T_EXEC(5), .T_CLR(20)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_lcd_word(word),
    .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_data(lcd_data), .o_lcd_busy(lcd_busy), .o_lcd_ovf(lcd_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_c;
  } vec_t;

  vec_t vecs[8];

  // Pulse log filled by observe(): indices count negedges from the call.
  int         p_n, p_end, p_unstable;
  int         p_start[8];
  int         p_len[8];
  logic [7:0] p_data[8];
  logic       p_rs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic observe(input int max_cyc);
    logic prev_en;
    prev_en    = lcd_en;
    p_n        = 0;
    p_end      = -1;
    p_unstable = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        if (p_n < 8) begin
          p_start[p_n] = i;
          p_len[p_n]   = 0;
          p_data[p_n]  = lcd_data;
          p_rs[p_n]    = lcd_rs;
        end
        p_n++;
      end
      if (lcd_en && p_n > 0 && p_n <= 8) begin
        p_len[p_n-1]++;
        if (lcd_data !== p_data[p_n-1] || lcd_rs !== p_rs[p_n-1]) p_unstable++;
      end
      prev_en = lcd_en;
      if (!lcd_busy) begin
        p_end = i;
        break;
      end
    end
    checks++;
    if (p_end < 0) begin
      errors++;
      $display("FAIL observe_timeout: busy still %0b after %0d cycles expected 0", lcd_busy, max_cyc);
    end
  endtask

  task automatic check_init();
    int         exp_start[4];
    logic [7:0] exp_data[4];
    exp_start = '{12, 25, 38, 66};
    exp_data  = '{8'h38, 8'h0C, 8'h01, 8'h06};
    observe(300);
    chk("init_pulses", p_n, 4);
    for (int k = 0; k < 4 && k < p_n; k++) begin
      chk($sformatf("init_start%0d", k), p_start[k], exp_start[k]);
      chk($sformatf("init_len%0d", k), p_len[k], 3);
      chk($sformatf("init_data%0d", k), {24'd0, p_data[k]}, {24'd0, exp_data[k]});
      chk($sformatf("init_rs%0d", k), {31'd0, p_rs[k]}, 32'd0);
    end
    chk("init_end", p_end, 76);
    chk("init_unstable", p_unstable, 0);
  endtask

  task automatic send(input logic rs, input logic [7:0] data);
    word[9]   = rs;
    word[7:0] = data;
    word[8]   = ~word[8];
  endtask

  initial begin
    int found;
    vecs[0] = '{1'b1, 8'h41, 5};
    vecs[1] = '{1'b0, 8'h02, 20};
    vecs[2] = '{1'b0, 8'h80, 5};
    vecs[3] = '{1'b0, 8'h01, 20};
    vecs[4] = '{1'b0, 8'h03, 20};
    vecs[5] = '{1'b1, 8'h01, 5};
    vecs[6] = '{1'b0, 8'h04, 5};
    vecs[7] = '{1'b1, 8'hFF, 5};

    word  = 32'h8000_0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_on", {31'd0, lcd_on}, 32'd0);
    chk("rst_busy", {31'd0, lcd_busy}, 32'd1);
    chk("rst_ovf", {31'd0, lcd_ovf}, 32'd0);

    rst_n = 1'b1;
    check_init();
    chk("on_after_init", {31'd0, lcd_on}, 32'd1);

    // Single transfers from IDLE: 1 IDLE + 2 SETUP + 3 EN + 2 HOLD + WAIT.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].rs, vecs[v].data);
      observe(100);
      chk($sformatf("v%0d_pulses", v), p_n, 1);
      chk($sformatf("v%0d_start", v), p_start[0], 3);
      chk($sformatf("v%0d_len", v), p_len[0], 3);
      chk($sformatf("v%0d_data", v), {24'd0, p_data[0]}, {24'd0, vecs[v].data});
      chk($sformatf("v%0d_rs", v), {31'd0, p_rs[0]}, {31'd0, vecs[v].rs});
      chk($sformatf("v%0d_end", v), p_end, 8 + vecs[v].wait_c);
      chk($sformatf("v%0d_rw", v), {31'd0, lcd_rw}, 32'd0);
    end

    // Power bit toggled mid-transfer.
    send(1'b1, 8'h10);
    @(negedge clk);
    @(negedge clk);
    word[31] = 1'b0;
    @(negedge clk);
    chk("on_fall", {31'd0, lcd_on}, 32'd0);
    observe(100);
    chk("on_xfer_start", p_start[0], 0);
    chk("on_xfer_len", p_len[0], 3);
    chk("on_xfer_data", {24'd0, p_data[0]}, 32'h10);
    chk("on_xfer_end", p_end, 10);
    word[31] = 1'b1;
    @(negedge clk);
    chk("on_rise", {31'd0, lcd_on}, 32'd1);

    // Three requests during one transfer: second buffered, third dropped.
    send(1'b1, 8'h41);
    @(negedge clk);
    @(negedge clk);
    send(1'b1, 8'h42);
    @(negedge clk);
    @(negedge clk);
    chk("ovf_before", {31'd0, lcd_ovf}, 32'd0);
    send(1'b1, 8'h43);
    @(negedge clk);
    chk("ovf_set", {31'd0, lcd_ovf}, 32'd1);
    observe(200);
    chk("ovf_pulses", p_n, 1);
    chk("ovf_data", {24'd0, p_data[0]}, 32'h42);
    chk("ovf_start", p_start[0], 11);
    chk("ovf_end", p_end, 21);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", {31'd0, lcd_ovf}, 32'd1);
    chk("ovf_idle", {31'd0, lcd_busy}, 32'd0);

    // Drain and fill in the same IDLE cycle, then reset during EN_HI.
    send(1'b1, 8'h55);
    @(negedge clk);
    send(1'b1, 8'h66);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lcd_en) begin
        found = 1;
        break;
      end
    end
    chk("mid_en_seen", found, 1);
    chk("mid_en_data", {24'd0, lcd_data}, 32'h55);
    chk("mid_buf_busy", {31'd0, lcd_busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_en", {31'd0, lcd_en}, 32'd0);
    chk("mid_rst_ovf", {31'd0, lcd_ovf}, 32'd0);
    chk("mid_rst_data", {24'd0, lcd_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, lcd_busy}, 32'd1);
    word[8] = ~word[8];
    @(negedge clk);
    rst_n = 1'b1;
    check_init();
    repeat (5) @(negedge clk);
    chk("final_idle", {31'd0, lcd_busy}, 32'd0);
    chk("final_ovf", {31'd0, lcd_ovf}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
